// File: rtl/avalon_pattern_filler_if.sv
// Avalon-MM burst write port between the pattern filler (master) and the DDR controller (slave).
interface avalon_pattern_filler_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic              avl_waitrequest_n;
    logic [ADDR_W-1:0] avl_address;
    logic [DATA_W-1:0] avl_writedata;
    logic              avl_write;
    logic              avl_burstbegin;
    logic [6:0]        avl_burstcount;

    modport master (
        input  avl_waitrequest_n,
        output avl_address, avl_writedata, avl_write, avl_burstbegin, avl_burstcount
    );

    modport slave (
        output avl_waitrequest_n,
        input  avl_address, avl_writedata, avl_write, avl_burstbegin, avl_burstcount
    );
endinterface

// File: rtl/avalon_pattern_filler.sv
// Fills one H_ACTIVE x V_ACTIVE frame over Avalon-MM bursts with a selectable test pattern.
// Optional macro FILL_ADDR_DATA_EN: mode 3 writes the pixel index instead of a checkerboard.
module avalon_pattern_filler #(
    parameter int                ADDR_W    = 27,
    parameter int                DATA_W    = 32,
    parameter int                H_ACTIVE  = 1920,
    parameter int                V_ACTIVE  = 1080,
    parameter int                BURST_LEN = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                    iCLK,
    input  logic                    iRST_n,
    input  logic                    iBUTTON,
    input  logic [1:0]              iMODE,
    input  logic [23:0]             iCOLOR,
    input  logic                    local_init_done,
    avalon_pattern_filler_if.master avl,
    output logic                    oBUSY,
    output logic                    oDONE,
    output logic [1:0]              c_state
);
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int RW    = $clog2(TOTAL + 1);
    // At least 6 bits so the 32x32 checkerboard can always look at bit 5.
    localparam int XW    = ($clog2(H_ACTIVE) > 6) ? $clog2(H_ACTIVE) : 6;
    localparam int YW    = ($clog2(V_ACTIVE) > 6) ? $clog2(V_ACTIVE) : 6;

    localparam logic [XW-1:0] X_Q1 = XW'(H_ACTIVE / 4);
    localparam logic [XW-1:0] X_Q2 = XW'(H_ACTIVE / 2);
    localparam logic [XW-1:0] X_Q3 = XW'(3 * H_ACTIVE / 4);
    localparam logic [YW-1:0] Y_Q1 = YW'(V_ACTIVE / 4);
    localparam logic [YW-1:0] Y_Q2 = YW'(V_ACTIVE / 2);
    localparam logic [YW-1:0] Y_Q3 = YW'(3 * V_ACTIVE / 4);

    localparam logic [23:0] C_RED   = 24'hFF0000;
    localparam logic [23:0] C_GREEN = 24'h00FF00;
    localparam logic [23:0] C_BLUE  = 24'h0000FF;
    localparam logic [23:0] C_WHITE = 24'hFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        btn_sync_reg;
    logic              btn_prev_reg;
    logic              fresh_reg;
    logic [1:0]        mode_reg;
    logic [23:0]       color_reg;
    logic [XW-1:0]     x_reg;
    logic [YW-1:0]     y_reg;
    logic [6:0]        beat_reg;
    logic [RW-1:0]     rem_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [6:0]        bcount_reg;
`ifdef FILL_ADDR_DATA_EN
    logic [RW-1:0]     idx_reg;
`endif

    logic              trig;
    logic              start;
    logic              accept;
    logic              last_beat;
    logic [23:0]       pixel;
    logic [DATA_W-1:0] data_word;

    function automatic logic [6:0] burst_for(input logic [RW-1:0] r);
        if (int'(r) < BURST_LEN)
            return 7'(r);
        return 7'(BURST_LEN);
    endfunction

    assign trig      = btn_prev_reg & ~btn_sync_reg[1];
    assign start     = ((state_reg == S_IDLE) || (state_reg == S_DONE)) && trig && local_init_done;
    assign accept    = (state_reg == S_BURST) && avl.avl_waitrequest_n;
    assign last_beat = accept && (beat_reg == bcount_reg - 7'd1);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_SETUP;
            S_SETUP: state_next = S_BURST;
            S_BURST: if (last_beat) state_next = (rem_reg == RW'(1)) ? S_DONE : S_SETUP;
            S_DONE:  if (start) state_next = S_SETUP;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            btn_sync_reg <= 2'b11;
            btn_prev_reg <= 1'b1;
            fresh_reg    <= 1'b0;
            mode_reg     <= 2'd0;
            color_reg    <= 24'h0;
            x_reg        <= '0;
            y_reg        <= '0;
            beat_reg     <= 7'd0;
            rem_reg      <= '0;
            addr_reg     <= BASE_ADDR;
            bcount_reg   <= 7'd0;
`ifdef FILL_ADDR_DATA_EN
            idx_reg      <= '0;
`endif
        end else begin
            btn_sync_reg <= {btn_sync_reg[0], iBUTTON};
            btn_prev_reg <= btn_sync_reg[1];
            // SETUP entered from IDLE/DONE does the full frame init; the
            // inter-burst SETUP pass is only a one-cycle write gap.
            fresh_reg    <= start;
            if ((state_reg == S_SETUP) && fresh_reg) begin
                mode_reg   <= iMODE;
                color_reg  <= iCOLOR;
                x_reg      <= '0;
                y_reg      <= '0;
                beat_reg   <= 7'd0;
                rem_reg    <= RW'(TOTAL);
                addr_reg   <= BASE_ADDR;
                bcount_reg <= burst_for(RW'(TOTAL));
`ifdef FILL_ADDR_DATA_EN
                idx_reg    <= '0;
`endif
            end
            if (accept) begin
                if (x_reg == XW'(H_ACTIVE - 1)) begin
                    x_reg <= '0;
                    y_reg <= y_reg + YW'(1);
                end else begin
                    x_reg <= x_reg + XW'(1);
                end
                rem_reg <= rem_reg - RW'(1);
`ifdef FILL_ADDR_DATA_EN
                idx_reg <= idx_reg + RW'(1);
`endif
                if (last_beat) begin
                    beat_reg   <= 7'd0;
                    addr_reg   <= addr_reg + ADDR_W'(bcount_reg);
                    bcount_reg <= burst_for(rem_reg - RW'(1));
                end else begin
                    beat_reg   <= beat_reg + 7'd1;
                end
            end
        end
    end

    always_comb begin
        pixel = 24'h0;
        case (mode_reg)
            2'd0: pixel = color_reg;
            2'd1: pixel = (x_reg < X_Q1) ? C_RED : (x_reg < X_Q2) ? C_GREEN :
                          (x_reg < X_Q3) ? C_BLUE : C_WHITE;
            2'd2: pixel = (y_reg < Y_Q1) ? C_RED : (y_reg < Y_Q2) ? C_GREEN :
                          (y_reg < Y_Q3) ? C_BLUE : C_WHITE;
            default: pixel = (x_reg[5] ^ y_reg[5]) ? 24'h000000 : C_WHITE;
        endcase
    end

`ifdef FILL_ADDR_DATA_EN
    assign data_word = (mode_reg == 2'd3) ? DATA_W'(idx_reg) : DATA_W'(pixel);
`else
    assign data_word = DATA_W'(pixel);
`endif

    assign avl.avl_write      = (state_reg == S_BURST);
    assign avl.avl_burstbegin = (state_reg == S_BURST) && (beat_reg == 7'd0);
    assign avl.avl_address    = addr_reg;
    assign avl.avl_burstcount = bcount_reg;
    assign avl.avl_writedata  = (state_reg == S_BURST) ? data_word : '0;

    assign oBUSY   = (state_reg == S_SETUP) || (state_reg == S_BURST);
    assign oDONE   = (state_reg == S_DONE);
    assign c_state = state_reg;
endmodule

// File: tb/tb_avalon_pattern_filler.sv
// Scoreboard bench for avalon_pattern_filler: three small frame geometries driven from one directed sequence.
`timescale 1ns/1ps
module tb_avalon_pattern_filler;
    localparam int AW = 27;
    localparam int DW = 32;
    localparam int HA = 16, VA = 4,  BLA = 8;
    localparam int HB = 10, VB = 1,  BLB = 4;
    localparam int HC = 64, VC = 64, BLC = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [6:0]    bc;
        logic          bb;
        logic          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        wrq = 1'b1;
    logic [2:0]  btn = 3'b111;
    logic [1:0]  mode = 2'd0;
    logic [23:0] color = 24'h0;
    wire  [2:0]  busy, done;
    wire  [1:0]  st0, st1, st2;

    int          total = 0;
    int          bad = 0;
    beat_t       exp_q[3][$];
    int          gap[3] = '{0, 0, 0};
    int          acc[3] = '{0, 0, 0};
    logic [DW-1:0] cap_c [HC*VC];

    always #5 clk = ~clk;

    avalon_pattern_filler_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    avalon_pattern_filler_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
    avalon_pattern_filler_if #(.ADDR_W(AW), .DATA_W(DW)) bus_c ();
    assign bus_a.avl_waitrequest_n = wrq;
    assign bus_b.avl_waitrequest_n = wrq;
    assign bus_c.avl_waitrequest_n = wrq;

    avalon_pattern_filler #(.ADDR_W(AW), .DATA_W(DW), .H_ACTIVE(HA), .V_ACTIVE(VA), .BURST_LEN(BLA)) dut_a (
        .iCLK(clk), .iRST_n(rst_n), .iBUTTON(btn[0]), .iMODE(mode), .iCOLOR(color),
        .local_init_done(init_done), .avl(bus_a), .oBUSY(busy[0]), .oDONE(done[0]), .c_state(st0));
    avalon_pattern_filler #(.ADDR_W(AW), .DATA_W(DW), .H_ACTIVE(HB), .V_ACTIVE(VB), .BURST_LEN(BLB)) dut_b (
        .iCLK(clk), .iRST_n(rst_n), .iBUTTON(btn[1]), .iMODE(mode), .iCOLOR(color),
        .local_init_done(init_done), .avl(bus_b), .oBUSY(busy[1]), .oDONE(done[1]), .c_state(st1));
    avalon_pattern_filler #(.ADDR_W(AW), .DATA_W(DW), .H_ACTIVE(HC), .V_ACTIVE(VC), .BURST_LEN(BLC)) dut_c (
        .iCLK(clk), .iRST_n(rst_n), .iBUTTON(btn[2]), .iMODE(mode), .iCOLOR(color),
        .local_init_done(init_done), .avl(bus_c), .oBUSY(busy[2]), .oDONE(done[2]), .c_state(st2));

    function automatic logic [31:0] bar_color(input int b);
        case (b)
            0:       return 32'h00FF0000;
            1:       return 32'h0000FF00;
            2:       return 32'h000000FF;
            default: return 32'h00FFFFFF;
        endcase
    endfunction

    function automatic logic [31:0] pix(input int h, input int v, input logic [1:0] md,
                                        input logic [23:0] col, input int x, input int y);
        logic [31:0] r;
        r = 32'h0;
        case (md)
            2'd0: r = {8'h00, col};
            2'd1: r = bar_color((x < h/4) ? 0 : (x < h/2) ? 1 : (x < 3*h/4) ? 2 : 3);
            2'd2: r = bar_color((y < v/4) ? 0 : (y < v/2) ? 1 : (y < 3*v/4) ? 2 : 3);
            default: begin
`ifdef FILL_ADDR_DATA_EN
                r = 32'(y * h + x);
`else
                r = ((((x / 32) % 2) ^ ((y / 32) % 2)) == 0) ? 32'h00FFFFFF : 32'h0;
`endif
            end
        endcase
        return r;
    endfunction

    task automatic push_frame(input int i, input int h, input int v, input int bl,
                              input logic [1:0] md, input logic [23:0] col);
        beat_t e;
        int rem, base, n, idx;
        rem = h * v;
        base = 0;
        idx = 0;
        exp_q[i].delete();
        acc[i] = 0;
        while (rem > 0) begin
            n = (rem < bl) ? rem : bl;
            for (int k = 0; k < n; k++) begin
                e.addr = AW'(base);
                e.data = pix(h, v, md, col, idx % h, idx / h);
                e.bc   = 7'(n);
                e.bb   = (k == 0);
                e.last = (k == n - 1);
                exp_q[i].push_back(e);
                idx++;
            end
            base += n;
            rem  -= n;
        end
    endtask

    task automatic mon(input int i, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic bb, input logic [6:0] bc);
        beat_t e;
        if (gap[i] == 1) begin
            total++;
            assert (wr === 1'b0) else begin bad++; $error("FAIL gap%0d: write=%b expected 0", i, wr); end
            gap[i] = 2;
        end else if (gap[i] == 2) begin
            total++;
            assert (wr === 1'b1) else begin bad++; $error("FAIL resume%0d: write=%b expected 1", i, wr); end
            gap[i] = 0;
        end
        if (wr === 1'b1) begin
            total++;
            assert (exp_q[i].size() != 0) else begin
                bad++; $error("FAIL spurious%0d: write at addr=%0h expected no write", i, addr);
            end
            if (exp_q[i].size() != 0) begin
                e = exp_q[i][0];
                total++;
                assert (addr === e.addr) else begin bad++; $error("FAIL addr%0d: got %0h expected %0h", i, addr, e.addr); end
                total++;
                assert (data === e.data) else begin bad++; $error("FAIL data%0d: got %0h expected %0h", i, data, e.data); end
                total++;
                assert (bc === e.bc) else begin bad++; $error("FAIL bcount%0d: got %0d expected %0d", i, bc, e.bc); end
                total++;
                assert (bb === e.bb) else begin bad++; $error("FAIL bbegin%0d: got %b expected %b", i, bb, e.bb); end
                if (wrq) begin
                    void'(exp_q[i].pop_front());
                    acc[i]++;
                    if (i == 2 && acc[2] <= HC*VC) cap_c[acc[2]-1] = data;
                    if (e.last && exp_q[i].size() != 0) gap[i] = 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) gap[i] = 0;
        end else begin
            mon(0, bus_a.avl_write, bus_a.avl_address, bus_a.avl_writedata, bus_a.avl_burstbegin, bus_a.avl_burstcount);
            mon(1, bus_b.avl_write, bus_b.avl_address, bus_b.avl_writedata, bus_b.avl_burstbegin, bus_b.avl_burstcount);
            mon(2, bus_c.avl_write, bus_c.avl_address, bus_c.avl_writedata, bus_c.avl_burstbegin, bus_c.avl_burstcount);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin bad++; $error("FAIL %s: got %0h expected %0h", tag, obs, expv); end
    endtask

    task automatic press(input int i);
        btn[i] = 1'b0;
        tick(3);
        btn[i] = 1'b1;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        while (done[i] !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        total++;
        assert (done[i] === 1'b1) else begin bad++; $error("FAIL timeout%0d: done=%b expected 1", i, done[i]); end
    endtask

    task automatic chk_reset_a(input string pfx);
        chk({pfx, "_write"}, 32'(bus_a.avl_write), 0);
        chk({pfx, "_bbegin"}, 32'(bus_a.avl_burstbegin), 0);
        chk({pfx, "_addr"}, 32'(bus_a.avl_address), 0);
        chk({pfx, "_data"}, bus_a.avl_writedata, 0);
        chk({pfx, "_bcount"}, 32'(bus_a.avl_burstcount), 0);
        chk({pfx, "_busy"}, 32'(busy[0]), 0);
        chk({pfx, "_done"}, 32'(done[0]), 0);
        chk({pfx, "_state"}, 32'(st0), 0);
    endtask

    initial begin
        int n;
        tick(3);
        chk_reset_a("rst");
        rst_n = 1'b1;
        tick(2);

        // start is discarded while calibration is incomplete
        mode = 2'd0;
        color = 24'h123456;
        press(0);
        tick(6);
        chk("gate_state", 32'(st0), 0);
        chk("gate_write", 32'(bus_a.avl_write), 0);
        init_done = 1'b1;
        tick(5);
        chk("gate_not_queued", 32'(st0), 0);

        // solid fill with start-latency checks
        push_frame(0, HA, VA, BLA, 2'd0, 24'h123456);
        btn[0] = 1'b0;
        tick(2);
        chk("lat2_idle", 32'(st0), 0);
        tick(1);
        chk("lat3_setup", 32'(st0), 1);
        chk("lat3_busy", 32'(busy[0]), 1);
        btn[0] = 1'b1;
        tick(1);
        chk("lat4_burst", 32'(st0), 2);
        chk("lat4_bbegin", 32'(bus_a.avl_burstbegin), 1);
        tick(8);
        mode = 2'd1;
        press(0);
        wait_done(0, 300);
        chk("basic_state", 32'(st0), 3);
        chk("basic_busy", 32'(busy[0]), 0);
        chk("basic_beats", 32'(acc[0]), HA*VA);
        chk("basic_left", 32'(exp_q[0].size()), 0);
        tick(6);
        chk("ignored_trig", 32'(st0), 3);

        // restart from DONE with horizontal bands
        mode = 2'd2;
        push_frame(0, HA, VA, BLA, 2'd2, 24'h123456);
        press(0);
        chk("restart_done_clr", 32'(done[0]), 0);
        chk("restart_state", 32'(st0), 1);
        wait_done(0, 300);
        chk("bands_beats", 32'(acc[0]), HA*VA);
        chk("bands_left", 32'(exp_q[0].size()), 0);

        // backpressure mid-burst
        mode = 2'd1;
        push_frame(0, HA, VA, BLA, 2'd1, 24'h123456);
        press(0);
        tick(12);
        wrq = 1'b0;
        tick(3);
        chk("bp_write_held", 32'(bus_a.avl_write), 1);
        chk("bp_state_held", 32'(st0), 2);
        tick(2);
        wrq = 1'b1;
        wait_done(0, 300);
        chk("bp_beats", 32'(acc[0]), HA*VA);
        chk("bp_left", 32'(exp_q[0].size()), 0);

        // shortened final burst, vertical bars
        push_frame(1, HB, VB, BLB, 2'd1, 24'h123456);
        press(1);
        wait_done(1, 100);
        chk("short_beats", 32'(acc[1]), HB*VB);
        chk("short_left", 32'(exp_q[1].size()), 0);

        // mode 3 on the 64x64 frame
        mode = 2'd3;
        push_frame(2, HC, VC, BLC, 2'd3, 24'h123456);
        press(2);
        wait_done(2, 6000);
        chk("m3_beats", 32'(acc[2]), HC*VC);
`ifdef FILL_ADDR_DATA_EN
        chk("m3_pix100", cap_c[100], 32'h00000064);
`else
        chk("m3_pix_32_0", cap_c[32], 32'h00000000);
        chk("m3_pix_32_32", cap_c[32*HC+32], 32'h00FFFFFF);
`endif

        // asynchronous reset during the third burst
        mode = 2'd0;
        color = 24'hABCDEF;
        push_frame(0, HA, VA, BLA, 2'd0, 24'hABCDEF);
        press(0);
        n = 0;
        while (acc[0] < 18 && n < 200) begin
            tick(1);
            n++;
        end
        chk("midfill_reached", 32'(acc[0] >= 18), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_a("midrst");
        exp_q[0].delete();
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("post_rst_state", 32'(st0), 0);
        chk("post_rst_write", 32'(bus_a.avl_write), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
